// File: rtl/cache_pkg.sv
// Shared data-cache definitions: address field positions, line address width
// and the write-back drain state encoding.
package cache_pkg;

  localparam int ADR_WIDTH_DEF = 32;

  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 11;
  localparam int INDEX_MSB = 10;
  localparam int INDEX_LSB = 4;
  localparam int WORD_MSB  = 3;
  localparam int WORD_LSB  = 2;
  localparam int BYTE_MSB  = 1;
  localparam int BYTE_LSB  = 0;

  localparam int LINE_ADR_WIDTH = ADR_WIDTH_DEF - 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    POP
  } drain_state_t;

endpackage

// File: rtl/victim_wb_buffer_if.sv
// Victim write-back buffer bus: victim fill port, memory write port, snoop port
// and status flags. slave = the buffer, master = the cache/memory side.
interface victim_wb_buffer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
);

  logic                  vic_valid_i;
  logic                  vic_ready_o;
  logic [ADR_WIDTH-1:0]  vic_adr_i;
  logic [1:0]            vic_word_i;
  logic [WORD_WIDTH-1:0] vic_dat_i;

  logic                  mem_wr_req_o;
  logic [ADR_WIDTH-1:0]  mem_wr_adr_o;
  logic [WORD_WIDTH-1:0] mem_wr_dat_o;
  logic                  mem_wr_ack_i;

  logic [ADR_WIDTH-1:0]  snoop_adr_i;
  logic                  snoop_hit_o;
  logic [WORD_WIDTH-1:0] snoop_dat_o;

  logic                  full_o;
  logic                  empty_o;
  logic                  fill_err_o;

  modport slave (
    input  vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, mem_wr_ack_i, snoop_adr_i,
    output vic_ready_o, mem_wr_req_o, mem_wr_adr_o, mem_wr_dat_o,
           snoop_hit_o, snoop_dat_o, full_o, empty_o, fill_err_o
  );

  modport master (
    output vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, mem_wr_ack_i, snoop_adr_i,
    input  vic_ready_o, mem_wr_req_o, mem_wr_adr_o, mem_wr_dat_o,
           snoop_hit_o, snoop_dat_o, full_o, empty_o, fill_err_o
  );

endinterface

// File: rtl/victim_wb_buffer.sv
// Victim write-back buffer: collects evicted lines word by word and drains each
// line as four single-word memory writes. Define VICTIM_SNOOP_FWD_EN to forward buffered words on a snoop hit.
module victim_wb_buffer
  import cache_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF,
  parameter int WORD_NUM   = 4,
  parameter int DEPTH      = 2
) (
  input logic               clk,
  input logic               rst,
  victim_wb_buffer_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LINE_W = ADR_WIDTH - INDEX_LSB;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [LINE_W-1:0]     line_adr [DEPTH];
  logic [WORD_WIDTH-1:0] line_dat [DEPTH][WORD_NUM];
  logic [DEPTH-1:0]      valid;
  logic [WORD_NUM-1:0]   fill_mask;
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic [CNT_W-1:0]      count;

  drain_state_t          state;
  logic [1:0]            drain_word;
  logic                  req_q;
  logic [ADR_WIDTH-1:0]  adr_q;
  logic [WORD_WIDTH-1:0] dat_q;
  logic                  fill_err_q;

  logic                  ready;
  logic                  accept;
  logic [LINE_W-1:0]     vic_line;
  logic                  restart;
  logic                  line_clash;
  logic [WORD_NUM-1:0]   next_mask;
  logic                  complete;
  logic [1:0]            next_word;

  assign ready      = count < CNT_W'(DEPTH);
  assign accept     = bus.vic_valid_i && ready;
  assign vic_line   = bus.vic_adr_i[ADR_WIDTH-1:INDEX_LSB];
  assign line_clash = (fill_mask != '0) && (vic_line != line_adr[wr_ptr]);
  assign restart    = (fill_mask == '0) || line_clash;
  assign next_mask  = (restart ? '0 : fill_mask) | (WORD_NUM'(1) << bus.vic_word_i);
  assign complete   = accept && (next_mask == '1);
  assign next_word  = drain_word + 2'd1;

  // NOTE: line storage carries no reset; valid bits and the fill mask decide
  // which contents are live, so clearing the data array would only add muxes.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_dat[wr_ptr][bus.vic_word_i] <= bus.vic_dat_i;
      if (restart) line_adr[wr_ptr] <= vic_line;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every read sees the
  // pre-edge value, regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_mask  <= '0;
      valid      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fill_err_q <= 1'b0;
      state      <= IDLE;
      drain_word <= '0;
      req_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      fill_err_q <= accept && line_clash;
      if (accept) fill_mask <= complete ? '0 : next_mask;
      if (complete) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + ptr_t'(1);
      end
      count <= count + CNT_W'(complete) - CNT_W'(state == POP);

      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= REQ;
            drain_word <= '0;
            req_q      <= 1'b1;
            adr_q      <= {line_adr[rd_ptr], 2'b00, 2'b00};
            dat_q      <= line_dat[rd_ptr][0];
          end
        end
        REQ: begin
          if (bus.mem_wr_ack_i) begin
            if (drain_word == 2'd3) begin
              state <= POP;
              req_q <= 1'b0;
            end else begin
              drain_word <= next_word;
              adr_q      <= {line_adr[rd_ptr], next_word, 2'b00};
              dat_q      <= line_dat[rd_ptr][next_word];
            end
          end
        end
        POP: begin
          valid[rd_ptr] <= 1'b0;
          rd_ptr        <= rd_ptr + ptr_t'(1);
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vic_ready_o  = ready;
  assign bus.full_o       = count == CNT_W'(DEPTH);
  assign bus.empty_o      = (count == '0) && (fill_mask == '0);
  assign bus.fill_err_o   = fill_err_q;
  assign bus.mem_wr_req_o = req_q;
  assign bus.mem_wr_adr_o = adr_q;
  assign bus.mem_wr_dat_o = dat_q;

`ifdef VICTIM_SNOOP_FWD_EN
  logic [LINE_W-1:0] snoop_line;
  logic [1:0]        snoop_word;
  logic              hit;
  logic [WORD_WIDTH-1:0] hit_dat;
  ptr_t              idx;

  assign snoop_line = bus.snoop_adr_i[ADR_WIDTH-1:INDEX_LSB];
  assign snoop_word = bus.snoop_adr_i[WORD_MSB:WORD_LSB];

  // NOTE: every output gets a default first so no path infers a latch.
  // Oldest complete entry is scanned first so newer matches overwrite it.
  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    idx     = wr_ptr;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - ptr_t'(k);
      if (valid[idx] && (line_adr[idx] == snoop_line)) begin
        hit     = 1'b1;
        hit_dat = line_dat[idx][snoop_word];
      end
    end
    if (fill_mask[snoop_word] && (line_adr[wr_ptr] == snoop_line)) begin
      hit     = 1'b1;
      hit_dat = line_dat[wr_ptr][snoop_word];
    end
  end

  assign bus.snoop_hit_o = hit;
  assign bus.snoop_dat_o = hit_dat;
`else
  assign bus.snoop_hit_o = 1'b0;
  assign bus.snoop_dat_o = '0;
`endif

  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.vic_adr_i[INDEX_LSB-1:0], bus.snoop_adr_i};

endmodule
